axi_burst_responder: RTL and testbench
======================================

// Module: axi_burst_responder
// PURPOSE
// - AXI-like subordinate (responder) with a word-addressed memory. It terminates the write (AW/W/B)
//   and read (AR/R) channels driven by an initiator.
// - Serves as the reachable end-point when proving the write/read protocol-sequence covers.
// - Also serves as a reference target for initiator testbenches.
// - The write and read paths are independent FSMs that share one memory array.
// PARAMETERS
// ADDR_W      8   word-address width; the memory holds 2**ADDR_W words
// DATA_W      32  data width
// B_LATENCY   1   cycles from the accepted last W beat to bvalid (legal range 1..15)
// PORTS
// clk      in   1       clock, rising edge
// rst_n    in   1       asynchronous, active-low reset
// awvalid  in   1       write-address valid
// awready  out  1       write-address ready
// awaddr   in   ADDR_W  start word address of the write burst
// awlen    in   4       write burst beats minus 1 (0..15)
// wvalid   in   1       write-data valid
// wready   out  1       write-data ready
// wdata    in   DATA_W  write data
// wlast    in   1       last write beat
// bvalid   out  1       write response valid
// bready   in   1       write response ready
// bresp    out  2       2'b00 OKAY, 2'b10 SLVERR
// arvalid  in   1       read-address valid
// arready  out  1       read-address ready
// araddr   in   ADDR_W  start word address of the read burst
// arlen    in   4       read burst beats minus 1
// rvalid   out  1       read data valid
// rready   in   1       read data ready
// rdata    out  DATA_W  read data (registered)
// rlast    out  1       last read beat
// BEHAVIOUR
// - Reset values: all outputs 0.
//   - awready and arready rise in the first cycle after rst_n deasserts.
//   - Memory contents are not reset.
// - Reset mid-burst: the burst is abandoned and both FSMs return to IDLE. No response is issued.
// - Write FSM states: W_IDLE, W_DATA, W_BWAIT, W_RESP.
//   - W_IDLE: awready=1; wready=awvalid.
//     - This lets the first beat be accepted in the same cycle as the address.
//     - A W beat that arrives before AW waits: wready=0 until awvalid.
//   - On the AW handshake: latch awaddr/awlen and set beat count cnt=0.
//     - If the same-cycle W beat is the final beat, go to W_BWAIT; otherwise go to W_DATA.
//   - W_DATA: awready=0; wready=1. Each W handshake does:
//     - mem[addr] <= wdata
//     - addr <= addr+1, wrapping mod 2**ADDR_W
//     - cnt++
//   - Final beat: the earlier of (a) wlast=1 and (b) cnt==len.
//     - bresp=SLVERR if (a) and (b) do not coincide; otherwise OKAY.
//   - W_BWAIT: wait B_LATENCY-1 cycles, then go to W_RESP.
//     - Net effect: bvalid asserts exactly B_LATENCY cycles after the final-beat handshake.
//   - W_RESP: bvalid=1; bvalid and bresp are held stable until bready.
//     - On the B handshake go to W_IDLE, so awready=1 on the very next cycle.
// - Read FSM states: R_IDLE, R_DATA.
//   - R_IDLE: arready=1.
//   - On the AR handshake, the next cycle has:
//     - rvalid=1
//     - rdata=mem[araddr]
//     - rlast=(arlen==0)
//   - R_DATA: rvalid, rdata and rlast are held stable while rready=0.
//     - This holds even if that memory word is written meanwhile.
//   - On a non-last R handshake, load rdata with mem[addr+1] (wrapped) the same cycle, so there is
//     no bubble.
//   - After the rlast handshake: rvalid=0 and go to R_IDLE. arready=1 on the next cycle.
// - Simultaneous events:
//   - A read and a write to the same word in the same cycle: the read returns the old value
//     (read-before-write).
//   - AW and AR may both handshake in the same cycle.
// - Maximum one outstanding write and one outstanding read. There is no ID or reordering.
// CONFIGURATION
// - AXI_RSP_STALL_EN defined: an 8-bit Fibonacci LFSR produces random backpressure.
//   - Seed 8'hA5, reloaded on reset. Taps 8,6,5,4. Advances every cycle.
//   - When lfsr[0]==1, awready, wready and arready are forced to 0 that cycle.
//   - rvalid, bvalid and held data are unaffected.
// - AXI_RSP_STALL_EN undefined: the LFSR is absent and readys follow the FSM only.
// TESTING
// - Single-beat write of addr 0x10, awlen=0, wdata=0xDEADBEEF, wlast in the same cycle as AW, bready=1:
//   - Required: awready and wready both 1 in that cycle.
//   - Required: bvalid=1, bresp=00 one cycle later (B_LATENCY=1).
// - 4-beat write to 0xFE, data 1..4:
//   - Required: mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3, mem[0x01]=4 (address wraps).
//   - Required: bresp=OKAY.
// - Write with awlen=3 and wlast on beat 2:
//   - Required: the burst ends after 2 beats; bvalid with bresp=2'b10.
//   - Required: awready=1 the cycle after the B handshake.
// - Read burst from 0xFE, arlen=3, rready low for 3 cycles on beat 0:
//   - Required: rdata stays 1 while stalled; then 2,3,4 on consecutive cycles.
//   - Required: rlast only on value 4.
// - Write to addr 0x20 in the same cycle a read beat of 0x20 is loaded:
//   - Required: the read returns the old value; a subsequent read returns the new value.
// - Assert rst_n=0 during beat 2 of a write:
//   - Required: all outputs 0; no bvalid after release; awready=1 in the first post-reset cycle.

Source files
------------

// File: rtl/axi_burst_responder_if.sv
// Write (AW/W/B) and read (AR/R) channel bundle between an initiator and axi_burst_responder.
interface axi_burst_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              rlast;

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rlast
    );

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi_burst_responder.sv
// AXI-like burst responder over a word-addressed memory; independent write and read FSMs.
// Define AXI_RSP_STALL_EN to add LFSR-driven backpressure on awready/wready/arready.
module axi_burst_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int B_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    axi_burst_responder_if.slave bus
);
    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] BWAIT_INIT  = (B_LATENCY > 1) ? 4'(B_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_BWAIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_len;
    logic [3:0]        w_cnt;
    logic [3:0]        b_dly;
    logic              aw_rdy;
    logic              b_vld;
    logic [1:0]        b_resp;

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_nxt;
    logic [3:0]        r_left;
    logic              ar_rdy;
    logic              vld_p0;
    logic              r_last_p0;
    logic [DATA_W-1:0] r_data_p0;

    logic              stall;

`ifdef AXI_RSP_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    logic              aw_fire;
    logic              w_fire;
    logic              ar_fire;
    logic              r_fire;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [3:0]        w_beat_cnt;
    logic [3:0]        w_beat_len;
    logic              w_final;
    logic              w_last_ok;

    assign bus.awready = aw_rdy & ~stall;
    assign bus.wready  = ~stall & (aw_rdy ? bus.awvalid : (w_state == W_DATA));
    assign bus.arready = ar_rdy & ~stall;
    assign bus.bvalid  = b_vld;
    assign bus.bresp   = b_resp;
    assign bus.rvalid  = vld_p0;
    assign bus.rdata   = r_data_p0;
    assign bus.rlast   = r_last_p0;

    assign aw_fire = bus.awvalid & bus.awready;
    assign w_fire  = bus.wvalid & bus.wready;
    assign ar_fire = bus.arvalid & bus.arready;
    assign r_fire  = vld_p0 & bus.rready;

    // A beat accepted together with its address takes the burst fields straight from AW.
    assign w_beat_addr = aw_rdy ? bus.awaddr : w_addr;
    assign w_beat_cnt  = aw_rdy ? 4'd0 : w_cnt;
    assign w_beat_len  = aw_rdy ? bus.awlen : w_len;
    assign w_final     = bus.wlast | (w_beat_cnt == w_beat_len);
    assign w_last_ok   = bus.wlast & (w_beat_cnt == w_beat_len);

    always_ff @(posedge clk) begin
        if (w_fire) mem[w_beat_addr] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            aw_rdy  <= 1'b0;
            b_vld   <= 1'b0;
            b_resp  <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= 4'd0;
            w_cnt   <= 4'd0;
            b_dly   <= 4'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_rdy <= 1'b1;
                    if (aw_fire) begin
                        aw_rdy  <= 1'b0;
                        w_addr  <= bus.awaddr;
                        w_len   <= bus.awlen;
                        w_cnt   <= 4'd0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: ;
                W_BWAIT: begin
                    if (b_dly == 4'd0) begin
                        b_vld   <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        b_dly <= b_dly - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        b_vld   <= 1'b0;
                        aw_rdy  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase

            // Beat accounting overrides the IDLE defaults when W arrives with AW.
            if (w_fire) begin
                w_addr <= w_beat_addr + ADDR_W'(1);
                w_cnt  <= w_beat_cnt + 4'd1;
                if (w_final) begin
                    b_resp <= w_last_ok ? RESP_OKAY : RESP_SLVERR;
                    b_dly  <= BWAIT_INIT;
                    if (B_LATENCY <= 1) begin
                        b_vld   <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_state <= W_BWAIT;
                    end
                end
            end
        end
    end

    assign r_addr_nxt = r_addr + ADDR_W'(1);

    // Stage p0: registered read beat, held until the initiator takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            ar_rdy    <= 1'b0;
            vld_p0    <= 1'b0;
            r_last_p0 <= 1'b0;
            r_data_p0 <= '0;
            r_addr    <= '0;
            r_left    <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_rdy <= 1'b1;
                    if (ar_fire) begin
                        ar_rdy    <= 1'b0;
                        vld_p0    <= 1'b1;
                        r_data_p0 <= mem[bus.araddr];
                        r_last_p0 <= (bus.arlen == 4'd0);
                        r_addr    <= bus.araddr;
                        r_left    <= bus.arlen;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_last_p0) begin
                            vld_p0    <= 1'b0;
                            r_last_p0 <= 1'b0;
                            ar_rdy    <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_addr    <= r_addr_nxt;
                            r_data_p0 <= mem[r_addr_nxt];
                            r_last_p0 <= (r_left == 4'd1);
                            r_left    <= r_left - 4'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_responder.sv
// Randomized bench for axi_burst_responder with a transaction-level memory model checked every cycle.
module tb_axi_burst_responder;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int BL     = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_burst_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_burst_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .B_LATENCY(BL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: memory image plus burst bookkeeping.
    logic [31:0] mmem [256];
    bit          live;
    bit          w_busy;
    logic [7:0]  w_start;
    int          w_len, w_cnt;
    bit          b_pend;
    int          b_wait;
    logic [1:0]  b_resp_m;
    bit          r_busy;
    logic [7:0]  r_start;
    int          r_len, r_beat;
    logic [31:0] r_exp;
    bit          r_last_m;

    bit aw_f, w_f, b_f, ar_f, r_f, rl_f;
    int cyc = 0;
    int fin_cyc = 0;
    int b_lat_seen = -1;
    logic [1:0] b_resp_seen = 2'b11;
    bit bv_prev = 1'b0;
    bit aw_w_same = 1'b0;
    logic [32:0] rq[$];

    always @(negedge clk) begin
        bit e_widle;
        bit e_bvld;
        cyc++;
        if (!rst_n) begin
            chk("rst_awready", 32'(bus.awready), 32'd0);
            chk("rst_wready",  32'(bus.wready),  32'd0);
            chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
            chk("rst_bresp",   32'(bus.bresp),   32'd0);
            chk("rst_arready", 32'(bus.arready), 32'd0);
            chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
            chk("rst_rdata",   bus.rdata,        32'd0);
            chk("rst_rlast",   32'(bus.rlast),   32'd0);
            live = 0; w_busy = 0; b_pend = 0; r_busy = 0; bv_prev = 0;
            aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; rl_f = 0;
        end else begin
            e_widle = !w_busy && !b_pend;
            e_bvld  = b_pend && (b_wait == 0);
            chk("awready", 32'(bus.awready), 32'(live && e_widle));
            chk("wready",  32'(bus.wready),  32'(live && (e_widle ? bus.awvalid : w_busy)));
            chk("bvalid",  32'(bus.bvalid),  32'(e_bvld));
            if (e_bvld) chk("bresp", 32'(bus.bresp), 32'(b_resp_m));
            chk("arready", 32'(bus.arready), 32'(live && !r_busy));
            chk("rvalid",  32'(bus.rvalid),  32'(r_busy));
            if (r_busy) begin
                chk("rdata", bus.rdata, r_exp);
                chk("rlast", 32'(bus.rlast), 32'(r_last_m));
            end
            if (bus.bvalid && !bv_prev) begin
                b_lat_seen  = cyc - fin_cyc;
                b_resp_seen = bus.bresp;
            end
            bv_prev = bus.bvalid;

            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            b_f  = bus.bvalid && bus.bready;
            ar_f = bus.arvalid && bus.arready;
            r_f  = bus.rvalid && bus.rready;
            rl_f = r_f && bus.rlast;

            // Read loads see memory before this cycle's write lands.
            if (r_busy && bus.rready) begin
                rq.push_back({bus.rlast, bus.rdata});
                if (r_beat == r_len) begin
                    r_busy = 0;
                end else begin
                    r_beat++;
                    r_exp    = mmem[8'(r_start + r_beat)];
                    r_last_m = (r_beat == r_len);
                end
            end else if (!r_busy && ar_f) begin
                r_busy   = 1;
                r_start  = bus.araddr;
                r_len    = int'(bus.arlen);
                r_beat   = 0;
                r_exp    = mmem[bus.araddr];
                r_last_m = (bus.arlen == 4'd0);
            end

            if (e_bvld && bus.bready) b_pend = 0;
            else if (b_pend && b_wait > 0) b_wait--;
            if (e_widle && aw_f) begin
                w_busy  = 1;
                w_start = bus.awaddr;
                w_len   = int'(bus.awlen);
                w_cnt   = 0;
                if (w_f) aw_w_same = 1;
            end
            if (w_busy && w_f) begin
                mmem[8'(w_start + w_cnt)] = bus.wdata;
                if (bus.wlast || w_cnt == w_len) begin
                    b_resp_m = (bus.wlast && w_cnt == w_len) ? 2'b00 : 2'b10;
                    w_busy   = 0;
                    b_pend   = 1;
                    b_wait   = BL - 1;
                    fin_cyc  = cyc;
                end
                w_cnt++;
            end
            live = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = W with AW, 1 = W one cycle before AW, 2 = AW first. wl_at > len means no wlast.
    task automatic do_write(input logic [7:0] a, input logic [3:0] len, input int wl_at,
                            input logic [31:0] d0, input bit rnd, input int mode, input int bdly);
        int nb, beat, t;
        bit aw_done;
        nb = (wl_at < int'(len)) ? wl_at + 1 : int'(len) + 1;
        beat = 0; t = 0; aw_done = 0;
        bus.awaddr = a;
        bus.awlen  = len;
        if (mode != 1) bus.awvalid = 1'b1;
        if (mode != 2) begin
            bus.wvalid = 1'b1;
            bus.wdata  = rnd ? $urandom : d0;
            bus.wlast  = (wl_at == 0);
        end
        while ((!aw_done || beat < nb) && t < 400) begin
            tick();
            t++;
            if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_f) begin beat++; bus.wvalid = 1'b0; bus.wlast = 1'b0; end
            if (!aw_done && !bus.awvalid) bus.awvalid = 1'b1;
            if (!bus.wvalid && beat < nb && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.wvalid = 1'b1;
                bus.wdata  = rnd ? $urandom : d0 + 32'(beat);
                bus.wlast  = (beat == wl_at);
            end
        end
        chk("wr_done", 32'(aw_done && beat >= nb), 32'd1);
        bus.bready = (bdly == 0);
        t = 0;
        while (t < 100) begin
            tick();
            t++;
            if (b_f) break;
            if (t >= bdly) bus.bready = 1'b1;
        end
        bus.bready = 1'b0;
        chk("b_done", 32'(b_f), 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int stall0, input bit rnd);
        int t;
        bit done;
        t = 0; done = 0;
        bus.araddr  = a;
        bus.arlen   = len;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        do begin tick(); t++; end while (!ar_f && t < 100);
        bus.arvalid = 1'b0;
        chk("ar_done", 32'(ar_f), 32'd1);
        t = 0;
        do begin
            bus.rready = (t < stall0) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            tick();
            t++;
            if (rl_f) done = 1;
        end while (!done && t < 200);
        bus.rready = 1'b0;
        chk("rd_done", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pre42;
        int n, t, bv;
        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.rready = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_awready", 32'(bus.awready), 32'd1);
        chk("post_rst_arready", 32'(bus.arready), 32'd1);

        for (int k = 0; k < 16; k++) do_write(8'(k * 16), 4'd15, 15, 32'd0, 1'b1, 0, 0);

        aw_w_same = 0;
        do_write(8'h10, 4'd0, 0, 32'hDEADBEEF, 1'b0, 0, 0);
        chk("sb_aw_w_same", 32'(aw_w_same), 32'd1);
        chk("sb_b_latency", 32'(b_lat_seen), 32'd1);
        chk("sb_bresp", 32'(b_resp_seen), 32'd0);
        chk("sb_model_mem", mmem[8'h10], 32'hDEADBEEF);

        do_write(8'hFE, 4'd3, 3, 32'd1, 1'b0, 2, 2);
        chk("wrap_bresp", 32'(b_resp_seen), 32'd0);
        chk("wrap_mem_fe", mmem[8'hFE], 32'd1);
        chk("wrap_mem_ff", mmem[8'hFF], 32'd2);
        chk("wrap_mem_00", mmem[8'h00], 32'd3);
        chk("wrap_mem_01", mmem[8'h01], 32'd4);

        pre42 = mmem[8'h42];
        do_write(8'h40, 4'd3, 1, 32'hA0, 1'b0, 1, 1);
        chk("early_last_bresp", 32'(b_resp_seen), 32'd2);
        chk("early_last_awready_next", 32'(bus.awready), 32'd1);
        rq.delete();
        do_read(8'h40, 4'd2, 0, 1'b0);
        chk("early_last_rd_n", 32'(rq.size()), 32'd3);
        if (rq.size() == 3) begin
            chk("early_last_rd0", rq[0][31:0], 32'hA0);
            chk("early_last_rd1", rq[1][31:0], 32'hA1);
            chk("early_last_rd2", rq[2][31:0], pre42);
        end

        rq.delete();
        do_read(8'hFE, 4'd3, 3, 1'b0);
        chk("wrap_rd_n", 32'(rq.size()), 32'd4);
        if (rq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("wrap_rd_data", rq[i][31:0], 32'(i + 1));
                chk("wrap_rd_last", 32'(rq[i][32]), 32'(i == 3));
            end
        end

        do_write(8'h20, 4'd0, 0, 32'h11111111, 1'b0, 0, 0);
        rq.delete();
        fork
            do_write(8'h20, 4'd0, 0, 32'hCAFE0001, 1'b0, 0, 0);
            do_read(8'h20, 4'd0, 0, 1'b0);
        join
        chk("rbw_old", (rq.size() > 0) ? rq[0][31:0] : 32'hFFFF_FFFF, 32'h11111111);
        rq.delete();
        do_read(8'h20, 4'd0, 0, 1'b0);
        chk("rbw_new", (rq.size() > 0) ? rq[0][31:0] : 32'hFFFF_FFFF, 32'hCAFE0001);

        fork
            repeat (30) do_write({4'h3, 4'($urandom_range(0, 15))}, 4'($urandom_range(0, 15)),
                                 $urandom_range(0, 16), 32'd0, 1'b1, $urandom_range(0, 2),
                                 $urandom_range(0, 3));
            repeat (30) do_read({4'h3, 4'($urandom_range(0, 15))}, 4'($urandom_range(0, 15)),
                                $urandom_range(0, 2), 1'b1);
        join

        bus.awaddr = 8'h60; bus.awlen = 4'd3; bus.awvalid = 1'b1;
        bus.wvalid = 1'b1; bus.wdata = $urandom; bus.wlast = 1'b0;
        n = 0; t = 0;
        while (n < 2 && t < 50) begin
            tick();
            t++;
            if (aw_f) bus.awvalid = 1'b0;
            if (w_f) begin n++; bus.wdata = $urandom; end
        end
        chk("midrst_beats", 32'(n), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("midrst_wready", 32'(bus.wready), 32'd0);
        chk("midrst_awready", 32'(bus.awready), 32'd0);
        repeat (3) tick();
        bus.wvalid = 1'b0; bus.awvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("midrst_awready_first", 32'(bus.awready), 32'd1);
        bv = 0;
        repeat (10) begin tick(); bv += int'(bus.bvalid); end
        chk("midrst_no_b", 32'(bv), 32'd0);
        rq.delete();
        do_read(8'h60, 4'd1, 0, 1'b0);
        chk("midrst_rd_n", 32'(rq.size()), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
